biu_multi: RTL and testbench
============================

# biu_multi

Parametrised multi-slave bus interface unit, successor to the two-branch BIU. It sits between the CPU data port and up to NSLV memory-mapped slaves (DMEM, output peripheral, future peripherals). It decodes each request against per-slave base/mask windows and inserts a per-slave programmable number of wait states. It returns registered read data with a request/acknowledge handshake and records unmapped accesses as bus errors.

## Interface
Parameters:
- NSLV, 4, number of slave ports (1..8)
- AW, 32, address width
- DW, 32, data width
- SLV_BASE, {NSLV{AW'h0}}, packed slave base addresses, slave i at [i*AW +: AW]
- SLV_MASK, {NSLV{AW'h0}}, packed compare masks; slave i hit when (daddr & MASK_i) == (BASE_i & MASK_i)
- SLV_WAIT, {NSLV{4'h0}}, packed wait-state count per slave, 0..15

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- dreq  in  1  CPU request valid; daddr/dwdata/dwe held stable until dack
- daddr  in  AW  CPU byte address
- dwdata  in  DW  CPU write data
- dwe  in  DW/8  byte write enables; all-zero = read
- dack  out  1  one-cycle transaction complete
- derr  out  1  valid with dack; 1 = unmapped address
- drdata  out  DW  registered read data, valid with dack
- err_cnt  out  8  saturating count of unmapped accesses
- err_addr  out  AW  address of most recent unmapped access
- saddr  out  AW  latched address to all slaves
- swdata  out  DW  latched write data to all slaves
- swe  out  NSLV*DW/8  per-slave byte write strobes
- sre  out  NSLV  per-slave read strobes
- srdata  in  NSLV*DW  per-slave combinational read data

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: on dreq=1 latch daddr, dwdata, dwe, decoded index and hit flag; load wcnt = SLV_WAIT[idx]. Hit: go WAIT if wcnt>0, else ACCESS. Miss: go RESP with err pending.
- WAIT: decrement wcnt; when wcnt reaches 1 this cycle, go ACCESS.
- ACCESS: exactly one cycle; assert sre[idx] (read) or swe[idx] = latched dwe (write); capture srdata[idx] into drdata on reads; go RESP.
- RESP: dack=1 for one cycle; derr=err pending; go IDLE.
- Write response: drdata = 0. Error response: drdata = 0, err_cnt += 1 (saturate at 255), err_addr = latched address, both updated on the edge entering RESP.
- Overlapping windows: lowest index wins.
- dreq ignored outside IDLE; dreq still high in the IDLE cycle after dack starts a new transaction.
- Non-selected slaves: swe/sre always 0.

## Timing
- Latency dreq (sampled in IDLE) to dack: W+2 cycles for a hit with W wait states, 1 cycle for a miss.
- Max throughput: one hit per W+3 cycles.
- Strobes are single-cycle, registered-state driven; no combinational path from dreq/daddr to swe/sre/dack.
- Reset (any state, including mid-ACCESS): state IDLE; dack, derr, swe, sre deassert immediately; drdata, saddr, swdata, err_addr = 0; err_cnt = 0; wcnt = 0.

## Structure
- Package biu_pkg: state enum (IDLE, WAIT, ACCESS, RESP), WCNT_W = 4, ERRCNT_W = 8.
- Sub-module biu_decode: combinational priority decoder (daddr, SLV_BASE, SLV_MASK) -> hit, idx.
- Top: FSM, wait counter, latches, error registers.

## Test plan
- NSLV=2, slave0 base 0x0 mask 0xFFFFC000 wait 0; read 0x100, srdata0=0xDEADBEEF -> sre[0] one cycle, dack 2 cycles after dreq, drdata=0xDEADBEEF, derr=0.
- Slave1 base 0x34560 mask 0xFFFFFFF8 wait 3; write 0x34560 dwe=4'hF data 0x12345678 -> swe[7:4]=4'hF one cycle, dack 5 cycles after dreq, swe[3:0] stays 0.
- Read 0x80000000 (unmapped) -> dack+derr 1 cycle after dreq, drdata=0, err_cnt=1, err_addr=0x80000000; 300 misses -> err_cnt=255.
- Overlapping windows both covering 0x10 -> only slave 0 strobed.
- Assert reset during WAIT of slave1 -> no swe, no dack, all outputs 0; next request after release completes normally.
- Back-to-back: dreq held high across dack -> second transaction begins in the following IDLE cycle, exactly one strobe per transaction.

Source files
------------

// File: rtl/biu_pkg.sv
// Shared types and widths for the multi-slave bus interface unit.
package biu_pkg;
  localparam int WCNT_W   = 4;
  localparam int ERRCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;
endpackage

// File: rtl/biu_decode.sv
// Combinational priority address decoder: lowest-index matching window wins.
module biu_decode
  import biu_pkg::*;
#(
  parameter int                   NSLV     = 4,
  parameter int                   AW       = 32,
  parameter int                   IDX_W    = 2,
  parameter logic [NSLV*AW-1:0]   SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0]   SLV_MASK = '0
) (
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the last assignment made is the lowest matching index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/biu_multi.sv
// Multi-slave BIU: windowed decode, per-slave wait states, registered read data, unmapped-access logging.
// Hit latency W+2 cycles from accepted dreq to dack, miss latency 1; dreq is only sampled in IDLE.
module biu_multi
  import biu_pkg::*;
#(
  parameter int                     NSLV     = 4,
  parameter int                     AW       = 32,
  parameter int                     DW       = 32,
  parameter logic [NSLV*AW-1:0]     SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0]     SLV_MASK = '0,
  parameter logic [NSLV*WCNT_W-1:0] SLV_WAIT = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dreq,
  input  logic [AW-1:0]          daddr,
  input  logic [DW-1:0]          dwdata,
  input  logic [DW/8-1:0]        dwe,
  output logic                   dack,
  output logic                   derr,
  output logic [DW-1:0]          drdata,
  output logic [ERRCNT_W-1:0]    err_cnt,
  output logic [AW-1:0]          err_addr,
  output logic [AW-1:0]          saddr,
  output logic [DW-1:0]          swdata,
  output logic [NSLV*DW/8-1:0]   swe,
  output logic [NSLV-1:0]        sre,
  input  logic [NSLV*DW-1:0]     srdata
);

  localparam int BW    = DW / 8;
  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  state_t             state, nstate;
  logic [WCNT_W-1:0]  wcnt;
  logic [BW-1:0]      lat_we;
  logic [IDX_W-1:0]   lat_idx;
  logic               lat_hit;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [WCNT_W-1:0]  dec_wait;
  logic [DW-1:0]      rd_sel;

  biu_decode #(
    .NSLV     (NSLV),
    .AW       (AW),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (daddr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  always_comb begin
    dec_wait = '0;
    rd_sel   = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dec_idx == IDX_W'(i)) dec_wait = SLV_WAIT[i*WCNT_W +: WCNT_W];
      if (lat_idx == IDX_W'(i)) rd_sel   = srdata[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // Strobes depend only on registered state and latched request fields.
  always_comb begin
    nstate = state;
    sre    = '0;
    swe    = '0;
    case (state)
      IDLE: begin
        if (dreq) begin
          if (!dec_hit)            nstate = RESP;
          else if (dec_wait != '0) nstate = WAIT;
          else                     nstate = ACCESS;
        end
      end
      WAIT: begin
        if (wcnt <= WCNT_W'(1)) nstate = ACCESS;
      end
      ACCESS: begin
        nstate = RESP;
        for (int i = 0; i < NSLV; i++) begin
          if (lat_hit && lat_idx == IDX_W'(i)) begin
            if (lat_we == '0) sre[i]          = 1'b1;
            else              swe[i*BW +: BW] = lat_we;
          end
        end
      end
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign dack = (state == RESP);
  assign derr = dack && !lat_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt     <= '0;
      lat_we   <= '0;
      lat_idx  <= '0;
      lat_hit  <= 1'b0;
      saddr    <= '0;
      swdata   <= '0;
      drdata   <= '0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq) begin
            saddr   <= daddr;
            swdata  <= dwdata;
            lat_we  <= dwe;
            lat_idx <= dec_idx;
            lat_hit <= dec_hit;
            wcnt    <= dec_hit ? dec_wait : '0;
            drdata  <= '0;
            if (!dec_hit) begin
              err_addr <= daddr;
              if (err_cnt != {ERRCNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        WAIT:    wcnt   <= wcnt - 1'b1;
        ACCESS:  drdata <= (lat_we == '0) ? rd_sel : '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biu_multi.sv
// Bench for biu_multi: table vectors, random traffic against a window/latency model, reset and back-to-back corners.
module tb_biu_multi;
  localparam int NSLV = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  localparam logic [31:0] M_BASE [4] = '{32'h0000_0000, 32'h0003_4560, 32'h0003_4000, 32'h0000_0000};
  localparam logic [31:0] M_MASK [4] = '{32'hFFFF_C000, 32'hFFFF_FFF8, 32'hFFFF_F000, 32'hFFFF_FFE0};
  localparam int          M_WAIT [4] = '{0, 3, 15, 2};

  localparam logic [NSLV*AW-1:0] P_BASE = {M_BASE[3], M_BASE[2], M_BASE[1], M_BASE[0]};
  localparam logic [NSLV*AW-1:0] P_MASK = {M_MASK[3], M_MASK[2], M_MASK[1], M_MASK[0]};
  localparam logic [NSLV*4-1:0]  P_WAIT = {4'd2, 4'd15, 4'd3, 4'd0};

  logic                 clk, reset, dreq, dack, derr;
  logic [AW-1:0]        daddr, err_addr, saddr;
  logic [DW-1:0]        dwdata, drdata, swdata;
  logic [3:0]           dwe;
  logic [7:0]           err_cnt;
  logic [NSLV*4-1:0]    swe;
  logic [NSLV-1:0]      sre;
  logic [NSLV*DW-1:0]   srdata;
  logic [31:0]          srd [4];

  assign srdata = {srd[3], srd[2], srd[1], srd[0]};

  biu_multi #(
    .NSLV(NSLV), .AW(AW), .DW(DW),
    .SLV_BASE(P_BASE), .SLV_MASK(P_MASK), .SLV_WAIT(P_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .dack(dack), .derr(derr), .drdata(drdata), .err_cnt(err_cnt), .err_addr(err_addr),
    .saddr(saddr), .swdata(swdata), .swe(swe), .sre(sre), .srdata(srdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          m_errs = 0;
  logic [31:0] m_err_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference decode: first window (ascending index) that contains the address.
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & M_MASK[i]) == (M_BASE[i] & M_MASK[i])) return i;
    return -1;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         output int lat, output logic err, output logic [31:0] rd,
                         output int sre_cyc, output logic [3:0] sre_or,
                         output int swe_cyc, output logic [15:0] swe_or);
    @(negedge clk);
    dreq = 1'b1; daddr = a; dwdata = wd; dwe = we;
    lat = -1; err = 1'b0; rd = '0;
    sre_cyc = 0; swe_cyc = 0; sre_or = '0; swe_or = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (sre != '0) sre_cyc++;
      if (swe != '0) swe_cyc++;
      sre_or |= sre;
      swe_or |= swe;
      if (dack) begin
        lat = c; err = derr; rd = drdata;
        break;
      end
    end
    dreq = 1'b0; dwe = '0;
    @(posedge clk);
  endtask

  task automatic check_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                           input int exp_lat, input int exp_slv);
    int lat, sre_cyc, swe_cyc;
    logic err;
    logic [31:0] rd, exp_rd;
    logic [3:0]  sre_or, exp_sre;
    logic [15:0] swe_or, exp_swe;
    exp_rd = '0; exp_sre = '0; exp_swe = '0;
    if (exp_slv >= 0 && we == '0) begin exp_rd = srd[exp_slv]; exp_sre[exp_slv] = 1'b1; end
    if (exp_slv >= 0 && we != '0) exp_swe[exp_slv*4 +: 4] = we;
    if (exp_slv < 0) begin
      if (m_errs < 255) m_errs++;
      m_err_addr = a;
    end
    run_txn(a, wd, we, lat, err, rd, sre_cyc, sre_or, swe_cyc, swe_or);
    chk($sformatf("latency@%h", a), lat, exp_lat);
    chk($sformatf("derr@%h", a), err, exp_slv < 0);
    chk($sformatf("drdata@%h", a), rd, exp_rd);
    chk($sformatf("sre_cycles@%h", a), sre_cyc, (exp_sre != '0) ? 1 : 0);
    chk($sformatf("sre_sel@%h", a), sre_or, exp_sre);
    chk($sformatf("swe_cycles@%h", a), swe_cyc, (exp_swe != '0) ? 1 : 0);
    chk($sformatf("swe_val@%h", a), swe_or, exp_swe);
    chk($sformatf("err_cnt@%h", a), err_cnt, m_errs);
    chk($sformatf("err_addr@%h", a), err_addr, m_err_addr);
    chk($sformatf("saddr@%h", a), saddr, a);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    int          lat;
    int          slv;
  } vec_t;

  vec_t vt [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat, sre_cyc, swe_cyc, n_dack, d1, d2, s, region, bad;
    logic err;
    logic [31:0] rd, a, wd, rd1, rd2;
    logic [3:0] sre_or, we;
    logic [15:0] swe_or;

    vt[0] = '{32'h0000_0100, 32'h0,         4'h0, 2,  0};
    vt[1] = '{32'h0003_4560, 32'h1234_5678, 4'hF, 5,  1};
    vt[2] = '{32'h8000_0000, 32'h0,         4'h0, 1,  -1};
    vt[3] = '{32'h0000_0010, 32'h0,         4'h0, 2,  0};
    vt[4] = '{32'h0003_4567, 32'h0,         4'h0, 5,  1};
    vt[5] = '{32'h0003_4568, 32'h0,         4'h0, 17, 2};
    vt[6] = '{32'h0003_4000, 32'hA1B2_C3D4, 4'h5, 17, 2};
    vt[7] = '{32'h0000_3FFC, 32'h5555_AAAA, 4'h8, 2,  0};
    vt[8] = '{32'h0000_4000, 32'h0,         4'h0, 1,  -1};
    vt[9] = '{32'h0003_4570, 32'h0,         4'h0, 17, 2};

    srd[0] = 32'hDEAD_BEEF; srd[1] = 32'hCAFE_F00D; srd[2] = 32'h5A5A_1234; srd[3] = 32'h0BAD_C0DE;
    reset = 1'b1; dreq = 1'b0; daddr = '0; dwdata = '0; dwe = '0;
    repeat (2) @(negedge clk);
    chk("reset_dack", dack, 0);
    chk("reset_strobes", {swe, sre}, 0);
    chk("reset_drdata", drdata, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_saddr", saddr, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      check_txn(vt[i].addr, vt[i].wdata, vt[i].we, vt[i].lat, vt[i].slv);

    for (int n = 0; n < 40; n++) begin
      region = $urandom_range(0, 4);
      case (region)
        0:       a = $urandom_range(0, 32'h3FFF);
        1:       a = 32'h0003_4560 + $urandom_range(0, 7);
        2:       a = 32'h0003_4000 + $urandom_range(0, 32'hFFF);
        3:       a = $urandom;
        default: a = 32'h0000_4000 + $urandom_range(0, 32'hFFFF);
      endcase
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      for (int i = 0; i < 4; i++) srd[i] = $urandom;
      s = ref_slave(a);
      check_txn(a, wd, we, (s < 0) ? 1 : M_WAIT[s] + 2, s);
    end

    for (int n = 0; n < 300; n++) begin
      a = 32'h8000_0000 + 32'(n * 4);
      run_txn(a, 32'h0, 4'h0, lat, err, rd, sre_cyc, sre_or, swe_cyc, swe_or);
      if (m_errs < 255) m_errs++;
      m_err_addr = a;
    end
    chk("err_cnt_saturated", err_cnt, m_errs);
    chk("err_addr_after_burst", err_addr, m_err_addr);

    // Reset while slave 1 is counting down its wait states.
    @(negedge clk);
    dreq = 1'b1; daddr = 32'h0003_4560; dwdata = 32'hA5A5_A5A5; dwe = 4'hF;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1; dreq = 1'b0; dwe = '0;
    #1;
    chk("midreset_dack", {dack, derr}, 0);
    chk("midreset_strobes", {swe, sre}, 0);
    chk("midreset_regs", {drdata, saddr, swdata}, 0);
    chk("midreset_err", {err_cnt, err_addr}, 0);
    m_errs = 0; m_err_addr = '0;
    bad = 0;
    repeat (2) begin @(posedge clk); #1; if (dack || swe != '0 || sre != '0) bad = 1; end
    @(negedge clk); reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (dack || swe != '0 || sre != '0) bad = 1; end
    chk("no_activity_around_reset", bad, 0);
    check_txn(32'h0003_4561, 32'h0F0F_0F0F, 4'h3, 5, 1);
    check_txn(32'h8000_0000, 32'h0, 4'h0, 1, -1);

    // dreq held across dack: second read starts in the IDLE cycle after RESP.
    srd[0] = 32'h1111_2222;
    @(negedge clk);
    dreq = 1'b1; daddr = 32'h0000_0200; dwe = 4'h0;
    n_dack = 0; d1 = 0; d2 = 0; sre_cyc = 0; rd1 = '0; rd2 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (sre != '0) sre_cyc++;
      if (dack) begin
        n_dack++;
        if (n_dack == 1) begin d1 = c; rd1 = drdata; srd[0] = 32'h3333_4444; end
        else begin d2 = c; rd2 = drdata; dreq = 1'b0; end
      end
    end
    dreq = 1'b0;
    chk("b2b_dack_count", n_dack, 2);
    chk("b2b_first_dack", d1, 2);
    chk("b2b_second_dack", d2, 5);
    chk("b2b_sre_pulses", sre_cyc, 2);
    chk("b2b_rdata1", rd1, 32'h1111_2222);
    chk("b2b_rdata2", rd2, 32'h3333_4444);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
